// File: rtl/alu_pkg.sv
// Shared definitions for the RV32IM ALU: datapath width, opcode codes and
// the divide-by-zero result constant.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_XOR    = 5'd3;
  localparam logic [4:0] ALU_SRL    = 5'd4;
  localparam logic [4:0] ALU_SRA    = 5'd5;
  localparam logic [4:0] ALU_OR     = 5'd6;
  localparam logic [4:0] ALU_AND    = 5'd7;
  localparam logic [4:0] ALU_SLT    = 5'd8;
  localparam logic [4:0] ALU_SLTU   = 5'd9;
  localparam logic [4:0] ALU_MULHU  = 5'd16;
  localparam logic [4:0] ALU_MULHSU = 5'd17;
  localparam logic [4:0] ALU_MULH   = 5'd18;
  localparam logic [4:0] ALU_MUL    = 5'd22;
  localparam logic [4:0] ALU_DIV    = 5'd24;
  localparam logic [4:0] ALU_DIVU   = 5'd26;
  localparam logic [4:0] ALU_REM    = 5'd28;
  localparam logic [4:0] ALU_REMU   = 5'd30;

  localparam logic [XLEN-1:0] DIV_BY_ZERO = 32'hFFFF_FFFF;

endpackage

// File: rtl/alu_muldiv.sv
// Combinational M-extension unit: multiply high/low, signed/unsigned divide
// and remainder, sharing one 64-bit multiplier and one unsigned divider.
module alu_muldiv
  import alu_pkg::*;
(
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  logic              a_signed, b_signed;
  logic signed [XLEN:0]     a_ext, b_ext;
  logic signed [2*XLEN-1:0] a_wide, b_wide, product;

  assign a_signed = (op == ALU_MULH) || (op == ALU_MULHSU);
  assign b_signed = (op == ALU_MULH);
  assign a_ext    = {a_signed & a[XLEN-1], a};
  assign b_ext    = {b_signed & b[XLEN-1], b};
  assign a_wide   = {{(XLEN-1){a_ext[XLEN]}}, a_ext};
  assign b_wide   = {{(XLEN-1){b_ext[XLEN]}}, b_ext};
  assign product  = a_wide * b_wide;

  // Signed division runs on magnitudes; the overflow case falls out naturally
  // because |0x80000000| = 0x80000000 and the quotient sign stays positive.
  logic            div_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, b_safe, quot_mag, rem_mag, quot, rem;

  assign div_signed = (op == ALU_DIV) || (op == ALU_REM);
  assign a_neg      = div_signed & a[XLEN-1];
  assign b_neg      = div_signed & b[XLEN-1];
  assign a_mag      = a_neg ? -a : a;
  assign b_mag      = b_neg ? -b : b;
  assign b_safe     = (b == '0) ? {{(XLEN-1){1'b0}}, 1'b1} : b_mag;
  assign quot_mag   = a_mag / b_safe;
  assign rem_mag    = a_mag % b_safe;
  assign quot       = (a_neg ^ b_neg) ? -quot_mag : quot_mag;
  assign rem        = a_neg ? -rem_mag : rem_mag;

  always_comb begin
    result = '0;
    case (op)
      ALU_MUL:                      result = product[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: result = product[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:            result = (b == '0) ? DIV_BY_ZERO : quot;
      ALU_REM, ALU_REMU:            result = (b == '0) ? a : rem;
      default:                      result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// RV32IM execute-stage ALU with a single registered output (one-cycle latency).
// Define ALU_MULDIV_EN to build the multiply/divide unit; otherwise those ops return 0.
module alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      aluop,
  input  logic [XLEN-1:0] aluin1,
  input  logic [XLEN-1:0] aluin2,
  output logic [XLEN-1:0] aluout
);

  logic [XLEN-1:0] base_result, md_result, result_next, aluout_reg;
  logic [4:0]      shamt;

  assign shamt = aluin2[4:0];

  always_comb begin
    base_result = '0;
    case (aluop)
      ALU_ADD:  base_result = aluin1 + aluin2;
      ALU_SUB:  base_result = aluin1 - aluin2;
      ALU_SLL:  base_result = aluin1 << shamt;
      ALU_XOR:  base_result = aluin1 ^ aluin2;
      ALU_SRL:  base_result = aluin1 >> shamt;
      ALU_SRA:  base_result = $signed(aluin1) >>> shamt;
      ALU_OR:   base_result = aluin1 | aluin2;
      ALU_AND:  base_result = aluin1 & aluin2;
      ALU_SLT:  base_result = {{(XLEN-1){1'b0}}, $signed(aluin1) < $signed(aluin2)};
      ALU_SLTU: base_result = {{(XLEN-1){1'b0}}, aluin1 < aluin2};
      default:  base_result = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  alu_muldiv u_muldiv (
    .op     (aluop),
    .a      (aluin1),
    .b      (aluin2),
    .result (md_result)
  );
`else
  assign md_result = '0;
`endif

  // Every M-extension code has bit 4 set; no base op does.
  assign result_next = aluop[4] ? md_result : base_result;

  always_ff @(posedge clk) begin
    if (!rst_n) aluout_reg <= '0;
    else        aluout_reg <= result_next;
  end

  assign aluout = aluout_reg;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors plus randomized back-to-back
// ops checked against a plain-arithmetic reference model.
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  aluop = '0;
  logic [31:0] aluin1 = '0;
  logic [31:0] aluin2 = '0;
  logic [31:0] aluout;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .aluop  (aluop),
    .aluin1 (aluin1),
    .aluin2 (aluin2),
    .aluout (aluout)
  );

  always #5 clk = ~clk;

  task automatic check_result(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    longint          p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return a ^ b;
      5'd4:  return a >> b[4:0];
      5'd5:  begin p = sa >>> b[4:0]; return p[31:0]; end
      5'd6:  return a | b;
      5'd7:  return a & b;
      5'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd9:  return (ua < ub) ? 32'd1 : 32'd0;
`ifdef ALU_MULDIV_EN
      5'd16: begin p = longint'(ua * ub); return p[63:32]; end
      5'd17: begin p = sa * longint'(ub); return p[63:32]; end
      5'd18: begin p = sa * sb; return p[63:32]; end
      5'd22: begin p = longint'(ua * ub); return p[31:0]; end
      5'd24: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      5'd26: begin if (b == 0) return 32'hFFFF_FFFF; p = longint'(ua / ub); return p[31:0]; end
      5'd28: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      5'd30: begin if (b == 0) return a; p = longint'(ua % ub); return p[31:0]; end
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Directed expectations are written for the full RV32IM build.
  function automatic logic [31:0] build_exp(input logic [4:0] op, input logic [31:0] exp);
`ifdef ALU_MULDIV_EN
    return exp;
`else
    return (op >= 5'd16) ? 32'd0 : exp;
`endif
  endfunction

  // One op per negedge; the result of the previous op is checked first.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
    @(negedge clk);
    if (exp_q.size() > 0) check_result(tag_q.pop_front(), aluout, exp_q.pop_front());
    aluop  = op;
    aluin1 = a;
    aluin2 = b;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    @(negedge clk);
    if (exp_q.size() > 0) check_result(tag_q.pop_front(), aluout, exp_q.pop_front());
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'd32;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[$];
  logic [4:0] op_pool[18] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                              5'd16, 5'd17, 5'd18, 5'd22, 5'd24, 5'd26, 5'd28, 5'd30};

  initial begin
    vecs.push_back('{ALU_MUL,    32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, "mul_max_min"});
    vecs.push_back('{ALU_MUL,    32'hFFFF_FFFB, 32'd3,         32'hFFFF_FFF1, "mul_neg5x3"});
    vecs.push_back('{ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ones"});
    vecs.push_back('{ALU_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "mulhsu_m1x2"});
    vecs.push_back('{ALU_MULH,   32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, "mulh_min_max"});
    vecs.push_back('{ALU_DIV,    32'hFFFF_FFF1, 32'd3,         32'hFFFF_FFFB, "div_neg15_3"});
    vecs.push_back('{ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow"});
    vecs.push_back('{ALU_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, "div_by_zero"});
    vecs.push_back('{ALU_DIVU,   32'hFFFF_FFFF, 32'd3,         32'h5555_5555, "divu_ones_3"});
    vecs.push_back('{ALU_DIVU,   32'd17,        32'd3,         32'd5,         "divu_17_3"});
    vecs.push_back('{ALU_REM,    32'hFFFF_FFFB, 32'd2,         32'hFFFF_FFFF, "rem_neg5_2"});
    vecs.push_back('{ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_overflow"});
    vecs.push_back('{ALU_REM,    32'h8000_0000, 32'd3,         32'hFFFF_FFFE, "rem_min_3"});
    vecs.push_back('{ALU_REMU,   32'd5,         32'd0,         32'd5,         "remu_by_zero"});
    vecs.push_back('{ALU_REMU,   32'hFFFF_FFFF, 32'd3,         32'd0,         "remu_ones_3"});
    vecs.push_back('{ALU_OR,     32'd5,         32'd3,         32'd7,         "or_5_3"});
    vecs.push_back('{ALU_AND,    32'd5,         32'd3,         32'd1,         "and_5_3"});
    vecs.push_back('{ALU_XOR,    32'd5,         32'd5,         32'd0,         "xor_5_5"});
    vecs.push_back('{ALU_SRL,    32'd8,         32'd3,         32'd1,         "srl_8_3"});
    vecs.push_back('{ALU_SRA,    32'hFFFF_FFF8, 32'd1,         32'hFFFF_FFFC, "sra_neg8_1"});
    vecs.push_back('{ALU_SRA,    32'hFFFF_FFF8, 32'd32,        32'hFFFF_FFF8, "sra_neg8_32"});
    vecs.push_back('{ALU_SRL,    32'd8,         32'd32,        32'd8,         "srl_8_32"});
    vecs.push_back('{ALU_SUB,    32'd3,         32'd5,         32'hFFFF_FFFE, "sub_3_5"});
    vecs.push_back('{ALU_SLL,    32'd1,         32'd31,        32'h8000_0000, "sll_1_31"});
    vecs.push_back('{ALU_SLT,    32'hFFFF_FFFF, 32'd1,         32'd1,         "slt_m1_1"});
    vecs.push_back('{ALU_SLTU,   32'hFFFF_FFFF, 32'd1,         32'd0,         "sltu_ones_1"});
    vecs.push_back('{5'd12,      32'd5,         32'd3,         32'd0,         "unlisted_12"});
    vecs.push_back('{5'd31,      32'd5,         32'd3,         32'd0,         "unlisted_31"});

    // Reset discards the op presented during it.
    rst_n  = 1'b0;
    aluop  = ALU_ADD;
    aluin1 = 32'd5;
    aluin2 = 32'd3;
    @(negedge clk);
    @(negedge clk);
    check_result("reset_add", aluout, 32'd0);
    rst_n = 1'b1;

    issue(ALU_ADD, 32'd5, 32'd3, 32'd8, "add_5_3");
    foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, build_exp(vecs[i].op, vecs[i].exp), vecs[i].tag);

    for (int i = 0; i < 400; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : op_pool[$urandom_range(0, 17)];
      a  = pick_operand();
      b  = pick_operand();
      issue(op, a, b, ref_alu(op, a, b), $sformatf("rand op=%0d a=%h b=%h", op, a, b));
    end
    drain();

    // Reset in the middle of traffic clears the output register.
    rst_n  = 1'b0;
    aluop  = ALU_ADD;
    aluin1 = 32'd1;
    aluin2 = 32'd1;
    @(negedge clk);
    check_result("midrun_reset", aluout, 32'd0);
    rst_n = 1'b1;
    issue(ALU_SUB, 32'd10, 32'd4, 32'd6, "sub_after_reset");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
